// File: rtl/ccm_ctr_sched.sv
// ccm_ctr_sched: CCM counter-mode sequencer.
// Groups an input byte stream into 16-byte blocks, builds {flag, nonce, count}
// counter blocks for the shared AES core and steps the byte buffer through
// the keystream XOR. Carries no data bytes itself.
// Build option: define CCM_CTR_CNT0_SKIP_EN to start (and wrap) the counter at 1,
// keeping count 0 free for the CBC-MAC tag block.
module ccm_ctr_sched #(
   parameter int unsigned WIDTH_NONCE = 100,
   parameter int unsigned WIDTH_FLAG  = 8,
   parameter int unsigned WIDTH_COUNT = 20
) (
   input  logic                   clk,
   input  logic                   kill_n,
   input  logic                   input_en,
   input  logic                   input_last,
   input  logic [WIDTH_NONCE-1:0] ccm_ctr_nonce,
   input  logic [WIDTH_FLAG-1:0]  ccm_ctr_flag,
   output logic                   out_ready,
   output logic                   buf_wr_en,
   output logic [3:0]             buf_wr_addr,
   output logic                   aes_req,
   output logic [127:0]           aes_ctr_block,
   input  logic                   aes_ack,
   input  logic                   aes_done,
   output logic                   xor_rd_en,
   output logic [3:0]             xor_rd_addr,
   output logic                   out_en,
   output logic                   out_last,
   output logic                   ctr_ovf
);

`ifdef CCM_CTR_CNT0_SKIP_EN
   localparam logic [WIDTH_COUNT-1:0] CntStart = WIDTH_COUNT'(1);
`else
   localparam logic [WIDTH_COUNT-1:0] CntStart = '0;
`endif

   typedef enum logic [2:0] {
      StIdle,
      StFill,
      StReq,
      StWait,
      StDrain
   } state_e;

   state_e                 state_q, state_d;
   logic [3:0]             byte_cnt_q, byte_cnt_d;
   logic [3:0]             rd_addr_q, rd_addr_d;
   logic [WIDTH_COUNT-1:0] count_q, count_d;
   logic                   last_blk_q, last_blk_d;
   logic                   ovf_q, ovf_d;
   logic [WIDTH_NONCE-1:0] nonce_q, nonce_d;
   logic [WIDTH_FLAG-1:0]  flag_q, flag_d;

   // Counter step taken at the end of every drained block; wraps to the start value.
   logic [WIDTH_COUNT-1:0] count_inc;
   logic                   count_wrap;

   // Next counter value and wrap detection.
   always_comb begin
      count_wrap = (count_q == '1);
      count_inc  = count_wrap ? CntStart : (count_q + WIDTH_COUNT'(1));
   end

   // State register and per-message context.
   always_ff @(posedge clk or negedge kill_n) begin
      if (!kill_n) begin
         state_q    <= StIdle;
         byte_cnt_q <= '0;
         rd_addr_q  <= '0;
         count_q    <= CntStart;
         last_blk_q <= 1'b0;
         ovf_q      <= 1'b0;
         nonce_q    <= '0;
         flag_q     <= '0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         rd_addr_q  <= rd_addr_d;
         count_q    <= count_d;
         last_blk_q <= last_blk_d;
         ovf_q      <= ovf_d;
         nonce_q    <= nonce_d;
         flag_q     <= flag_d;
      end
   end

   // Next-state logic and all handshake/buffer outputs.
   always_comb begin
      state_d       = state_q;
      byte_cnt_d    = byte_cnt_q;
      rd_addr_d     = rd_addr_q;
      count_d       = count_q;
      last_blk_d    = last_blk_q;
      ovf_d         = ovf_q;
      nonce_d       = nonce_q;
      flag_d        = flag_q;
      out_ready     = 1'b0;
      buf_wr_en     = 1'b0;
      buf_wr_addr   = '0;
      aes_req       = 1'b0;
      aes_ctr_block = '0;
      xor_rd_en     = 1'b0;
      xor_rd_addr   = '0;
      out_en        = 1'b0;
      out_last      = 1'b0;

      case (state_q)
         StIdle: begin
            out_ready = 1'b1;
            if (input_en) begin
               // First byte of a message: capture the per-message header fields.
               buf_wr_en  = 1'b1;
               nonce_d    = ccm_ctr_nonce;
               flag_d     = ccm_ctr_flag;
               byte_cnt_d = 4'd1;
               last_blk_d = input_last;
               state_d    = input_last ? StReq : StFill;
            end
         end

         StFill: begin
            out_ready = 1'b1;
            if (input_en) begin
               buf_wr_en   = 1'b1;
               buf_wr_addr = byte_cnt_q;
               byte_cnt_d  = byte_cnt_q + 4'd1;
               if ((byte_cnt_q == 4'd15) || input_last) begin
                  last_blk_d = input_last;
                  state_d    = StReq;
               end
            end
         end

         StReq: begin
            aes_req       = 1'b1;
            aes_ctr_block = {flag_q, nonce_q, count_q};
            if (aes_ack) begin
               state_d = StWait;
            end
         end

         StWait: begin
            rd_addr_d = '0;
            if (aes_done) begin
               state_d = StDrain;
            end
         end

         StDrain: begin
            xor_rd_en   = 1'b1;
            out_en      = 1'b1;
            xor_rd_addr = rd_addr_q;
            out_last    = last_blk_q && (rd_addr_q == 4'd15);
            rd_addr_d   = rd_addr_q + 4'd1;
            if (rd_addr_q == 4'd15) begin
               count_d    = count_inc;
               byte_cnt_d = '0;
               if (count_wrap) begin
                  ovf_d = 1'b1;
               end
               if (last_blk_q) begin
                  // Every message starts from the start value, whatever it reached.
                  count_d = CntStart;
                  state_d = StIdle;
               end else begin
                  state_d = StFill;
               end
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign ctr_ovf = ovf_q;

endmodule

// File: tb/tb_ccm_ctr_sched.sv
module tb_ccm_ctr_sched;
   localparam int NW = 116;
   localparam int FW = 8;
   localparam int CW = 4;
`ifdef CCM_CTR_CNT0_SKIP_EN
   localparam int START = 1;
`else
   localparam int START = 0;
`endif
   localparam int CMAX = (1 << CW) - 1;

   logic          clk;
   logic          kill_n;
   logic          input_en;
   logic          input_last;
   logic [NW-1:0] ccm_ctr_nonce;
   logic [FW-1:0] ccm_ctr_flag;
   logic          out_ready;
   logic          buf_wr_en;
   logic [3:0]    buf_wr_addr;
   logic          aes_req;
   logic [127:0]  aes_ctr_block;
   logic          aes_ack;
   logic          aes_done;
   logic          xor_rd_en;
   logic [3:0]    xor_rd_addr;
   logic          out_en;
   logic          out_last;
   logic          ctr_ovf;

   ccm_ctr_sched #(
      .WIDTH_NONCE(NW),
      .WIDTH_FLAG (FW),
      .WIDTH_COUNT(CW)
   ) dut (
      .clk          (clk),
      .kill_n       (kill_n),
      .input_en     (input_en),
      .input_last   (input_last),
      .ccm_ctr_nonce(ccm_ctr_nonce),
      .ccm_ctr_flag (ccm_ctr_flag),
      .out_ready    (out_ready),
      .buf_wr_en    (buf_wr_en),
      .buf_wr_addr  (buf_wr_addr),
      .aes_req      (aes_req),
      .aes_ctr_block(aes_ctr_block),
      .aes_ack      (aes_ack),
      .aes_done     (aes_done),
      .xor_rd_en    (xor_rd_en),
      .xor_rd_addr  (xor_rd_addr),
      .out_en       (out_en),
      .out_last     (out_last),
      .ctr_ovf      (ctr_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [127:0] blk;
      logic         ovf;
   } req_t;

   logic [3:0] exp_wr_q[$];
   req_t       exp_req_q[$];
   logic [4:0] exp_out_q[$];   // {last, addr}

   // Reference model state: counter value for the next block and sticky wrap flag.
   int ref_count;
   bit ref_ovf;

   // AES responder controls: -1 means random latency.
   int ack_force  = -1;
   int done_force = -1;
   logic done_real;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic note_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=timeout required=event", name);
   endtask

   function automatic logic [NW-1:0] rnd_nonce();
      return NW'({$urandom, $urandom, $urandom, $urandom});
   endfunction

   // Expected responses for an n-byte message from the block/counter rules.
   task automatic plan_msg(input int n, input logic [FW-1:0] f, input logic [NW-1:0] nc);
      int     blocks;
      req_t   r;
      blocks = (n + 15) / 16;
      for (int k = 0; k < blocks; k++) begin
         r.blk = {f, nc, CW'(ref_count)};
         r.ovf = ref_ovf;
         exp_req_q.push_back(r);
         for (int a = 0; a < 16; a++) begin
            exp_out_q.push_back({(k == blocks - 1) && (a == 15), 4'(a)});
         end
         if (ref_count == CMAX) begin
            ref_count = START;
            ref_ovf   = 1'b1;
         end else begin
            ref_count++;
         end
      end
      ref_count = START;
      for (int i = 0; i < n; i++) exp_wr_q.push_back(4'(i % 16));
   endtask

   // Drive one message; bytes offered while busy are stray and must be ignored.
   task automatic send_msg(input int n, input logic [FW-1:0] f, input logic [NW-1:0] nc,
                           input int idle_pct);
      int i;
      int guard;
      plan_msg(n, f, nc);
      i     = 0;
      guard = 0;
      while (i < n) begin
         @(posedge clk);
         #1;
         guard++;
         if (guard > 200) begin
            note_fail("byte_accept");
            break;
         end
         if (out_ready && ($urandom_range(99) >= idle_pct)) begin
            input_en      = 1'b1;
            input_last    = (i == n - 1);
            ccm_ctr_nonce = (i == 0) ? nc : rnd_nonce();
            ccm_ctr_flag  = (i == 0) ? f : FW'($urandom);
            i++;
            guard = 0;
         end else if (!out_ready && ($urandom_range(1) == 1)) begin
            input_en      = 1'b1;
            input_last    = 1'($urandom_range(1));
            ccm_ctr_nonce = rnd_nonce();
            ccm_ctr_flag  = FW'($urandom);
         end else begin
            input_en   = 1'b0;
            input_last = 1'($urandom_range(1));
         end
      end
      @(posedge clk);
      #1;
      input_en   = 1'b0;
      input_last = 1'b0;
   endtask

   task automatic wait_quiet();
      int t;
      for (t = 0; t < 3000; t++) begin
         @(negedge clk);
         if (exp_wr_q.size() == 0 && exp_req_q.size() == 0 && exp_out_q.size() == 0 && out_ready)
            break;
      end
      if (t == 3000) note_fail("drain_complete");
   endtask

   // AES core model: random ack latency (spurious done pulses meanwhile), then done.
   initial begin
      int dly;
      aes_ack   = 1'b0;
      aes_done  = 1'b0;
      done_real = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         aes_ack   = 1'b0;
         aes_done  = 1'b0;
         done_real = 1'b0;
         if (aes_req && kill_n) begin
            dly = (ack_force >= 0) ? ack_force : $urandom_range(7);
            repeat (dly) begin
               aes_done = ($urandom_range(3) == 0);
               @(posedge clk);
               #1;
               aes_done = 1'b0;
            end
            aes_ack = 1'b1;
            @(posedge clk);
            #1;
            aes_ack = 1'b0;
            dly = (done_force >= 0) ? done_force - 1 : $urandom_range(9);
            repeat (dly) begin
               @(posedge clk);
               #1;
            end
            aes_done  = 1'b1;
            done_real = 1'b1;
         end else if ($urandom_range(15) == 0) begin
            aes_done = 1'b1;
         end
      end
   end

   // Monitor: pops expectations whenever the DUT presents a write, request or output byte.
   initial begin
      logic         req_prev;
      logic         ack_prev;
      logic         done_prev;
      logic         oe_prev;
      logic [3:0]   addr_prev;
      logic [127:0] blk_hold;
      req_t         r;
      logic [4:0]   o;
      req_prev  = 1'b0;
      ack_prev  = 1'b0;
      done_prev = 1'b0;
      oe_prev   = 1'b0;
      addr_prev = '0;
      blk_hold  = '0;
      forever begin
         @(negedge clk);
         if (!kill_n) begin
            req_prev  = 1'b0;
            ack_prev  = 1'b0;
            done_prev = 1'b0;
            oe_prev   = 1'b0;
         end else begin
            if (buf_wr_en) begin
               if (exp_wr_q.size() == 0) chk("unexpected_write", 128'(buf_wr_en), 128'(0));
               else chk("wr_addr", 128'(buf_wr_addr), 128'(exp_wr_q.pop_front()));
            end
            if (req_prev) chk("req_hold_drop", 128'(aes_req), 128'(!ack_prev));
            if (aes_req && !req_prev) begin
               if (exp_req_q.size() == 0) chk("unexpected_req", 128'(aes_req), 128'(0));
               else begin
                  r = exp_req_q.pop_front();
                  chk("ctr_block", aes_ctr_block, r.blk);
                  chk("ovf_at_req", 128'(ctr_ovf), 128'(r.ovf));
               end
               blk_hold = aes_ctr_block;
            end else if (aes_req) begin
               chk("ctr_block_stable", aes_ctr_block, blk_hold);
            end
            if (aes_req || out_en) chk("busy_not_ready", 128'(out_ready), 128'(0));
            if (done_prev) chk("first_out_en", 128'(out_en), 128'(1));
            if (oe_prev && addr_prev != 4'd15) chk("drain_contig", 128'(out_en), 128'(1));
            if (oe_prev && addr_prev == 4'd15) begin
               chk("ready_after_drain", 128'(out_ready), 128'(1));
               chk("no_extra_out_en", 128'(out_en), 128'(0));
            end
            if (out_en) begin
               if (exp_out_q.size() == 0) chk("unexpected_out_en", 128'(out_en), 128'(0));
               else begin
                  o = exp_out_q.pop_front();
                  chk("out_addr_last", 128'({out_last, xor_rd_addr}), 128'(o));
                  chk("xor_rd_en", 128'(xor_rd_en), 128'(1));
               end
            end else if (out_last || xor_rd_en) begin
               chk("idle_out_flags", 128'({out_last, xor_rd_en}), 128'(0));
            end
            req_prev  = aes_req;
            ack_prev  = aes_ack;
            done_prev = done_real;
            oe_prev   = out_en;
            addr_prev = xor_rd_addr;
         end
      end
   end

   task automatic check_reset_vals(input string tag);
      chk({tag, "_out_ready"}, 128'(out_ready), 128'(1));
      chk({tag, "_strobes"},
          128'({buf_wr_en, aes_req, xor_rd_en, out_en, out_last, ctr_ovf}), 128'(0));
      chk({tag, "_addrs"}, 128'({buf_wr_addr, xor_rd_addr}), 128'(0));
      chk({tag, "_ctr_block"}, aes_ctr_block, 128'(0));
   endtask

   initial begin
      int t;
      kill_n        = 1'b1;
      input_en      = 1'b0;
      input_last    = 1'b0;
      ccm_ctr_nonce = '0;
      ccm_ctr_flag  = '0;
      ref_count     = START;
      ref_ovf       = 1'b0;
      #2 kill_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check_reset_vals("reset");
      #1 kill_n = 1'b1;

      // Single 16-byte block, immediate ack, done 10 cycles later.
      ack_force  = 0;
      done_force = 10;
      send_msg(16, 8'h5B, NW'(1), 0);
      wait_quiet();

      // Three-block message with random AES latency and input gaps.
      ack_force  = -1;
      done_force = -1;
      send_msg(34, FW'($urandom), rnd_nonce(), 20);
      wait_quiet();

      // Slow ack: request and counter block must hold for 7 cycles.
      ack_force = 7;
      send_msg(20, FW'($urandom), rnd_nonce(), 0);
      wait_quiet();
      ack_force = -1;

      for (int m = 0; m < 8; m++) begin
         send_msg($urandom_range(1, 40), FW'($urandom), rnd_nonce(), 30);
      end
      wait_quiet();

      // 17 blocks in one message walk the 4-bit counter through its wrap.
      send_msg(272, FW'($urandom), rnd_nonce(), 5);
      wait_quiet();
      chk("ovf_after_wrap", 128'(ctr_ovf), 128'(1));

      for (int m = 0; m < 2; m++) begin
         send_msg($urandom_range(1, 40), FW'($urandom), rnd_nonce(), 10);
      end
      wait_quiet();
      chk("ovf_sticky", 128'(ctr_ovf), 128'(1));

      // Reset in the middle of a drain.
      send_msg(40, FW'($urandom), rnd_nonce(), 0);
      for (t = 0; t < 400; t++) begin
         @(negedge clk);
         if (out_en && xor_rd_addr == 4'd5) break;
      end
      if (t == 400) note_fail("reach_mid_drain");
      #2 kill_n = 1'b0;
      #1;
      check_reset_vals("kill");
      exp_wr_q.delete();
      exp_req_q.delete();
      exp_out_q.delete();
      ref_count = START;
      ref_ovf   = 1'b0;
      @(negedge clk);
      #2 kill_n = 1'b1;

      send_msg(5, FW'($urandom), rnd_nonce(), 0);
      wait_quiet();
      repeat (5) @(negedge clk);
      chk("final_ovf", 128'(ctr_ovf), 128'(0));
      chk("queues_empty", 128'(exp_wr_q.size() + exp_req_q.size() + exp_out_q.size()),
          128'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
